// File: rtl/c2_cfg_loader_if.sv
// c2_cfg_loader_if: serial configuration handshake and committed-frame bus
// between a frame source (master) and the C2 configuration loader (slave).
interface c2_cfg_loader_if #(
    parameter int NUM_CELLS = 4
);
    localparam int W = 4 * NUM_CELLS;

    logic         start;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [W-1:0] cfg_out;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, bit_in, bit_valid,
        input  bit_ready, cfg_out, busy, done, err
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output bit_ready, cfg_out, busy, done, err
    );
endinterface

// File: rtl/c2_cfg_loader.sv
// c2_cfg_loader: serial loader for a bank of Actel_C2-style mux cells.
// Bits arrive MSB first over valid/ready into a shadow register; the full
// frame is committed atomically to cfg_out so the cells never see a partial
// frame. Cell k takes cfg_out[4k+3:4k] as {d11, d10, d01, d00}.
// Optional feature: define C2_CFG_PARITY_EN to append an even-parity bit to
// each frame; a bad frame is dropped and flags a sticky err.
module c2_cfg_loader #(
    parameter int NUM_CELLS = 4
) (
    input  logic             clk,
    input  logic             rst,
    c2_cfg_loader_if.slave   bus
);
    localparam int              W    = 4 * NUM_CELLS;
    localparam int              CW   = $clog2(W + 1);
    localparam logic [CW-1:0]   LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
`ifdef C2_CFG_PARITY_EN
        ,
        PARITY = 2'd3
`endif
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   shadow;
    logic [W-1:0]   cfg;
    logic [CW-1:0]  cnt;
    logic           done_q;
    logic           ready;
    logic           xfer;
    logic           commit_ok;

    // ready decodes the state register only, so it never follows bit_valid
`ifdef C2_CFG_PARITY_EN
    assign ready = (state == SHIFT) || (state == PARITY);
`else
    assign ready = (state == SHIFT);
`endif
    assign xfer = bus.bit_valid & ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start) state_nxt = SHIFT;
            SHIFT: begin
                if (xfer && cnt == LAST) begin
`ifdef C2_CFG_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = COMMIT;
`endif
                end
            end
`ifdef C2_CFG_PARITY_EN
            PARITY: if (xfer) state_nxt = COMMIT;
`endif
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: shadow and counter are reset too, so an aborted frame leaves
        // no residue that a later frame could observe.
        if (rst) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (state == IDLE && bus.start) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (state == SHIFT && xfer) begin
            shadow <= {shadow[W-2:0], bus.bit_in};
            cnt    <= cnt + 1'b1;
        end
    end

`ifdef C2_CFG_PARITY_EN
    logic par_bad;
    logic err_q;

    // Parity check on the trailing bit and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                par_bad <= 1'b0;
                err_q   <= 1'b0;
            end else if (state == PARITY && xfer) begin
                par_bad <= (^shadow) ^ bus.bit_in;
            end else if (state == COMMIT && par_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign commit_ok = ~par_bad;
    assign bus.err   = err_q;
`else
    assign commit_ok = 1'b1;
    assign bus.err   = 1'b0;
`endif

    // Atomic commit of the shadow frame and end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == COMMIT);
            if (state == COMMIT && commit_ok) cfg <= shadow;
        end
    end

    assign bus.cfg_out   = cfg;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);
    assign bus.bit_ready = ready;
endmodule

// File: tb/tb_c2_cfg_loader.sv
// tb_c2_cfg_loader: directed and randomized checks of c2_cfg_loader against
// a frame-level reference model (expected frame, cycle count, parity result).
// Follows C2_CFG_PARITY_EN when it is defined for the build.
module tb_c2_cfg_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c2_cfg_loader_if #(.NUM_CELLS(2)) bus2 ();
    c2_cfg_loader_if #(.NUM_CELLS(1)) bus1 ();

    c2_cfg_loader #(.NUM_CELLS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    c2_cfg_loader #(.NUM_CELLS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef C2_CFG_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cfg;
    logic       exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on the 8-bit loader: gap_mask[i] inserts gap_len idle cycles
    // after transfer i; start_mid pulses start alongside transfer start_mid.
    task automatic run_frame2(input logic [7:0] data, input logic [15:0] gap_mask,
                              input int gap_len, input int start_mid, input logic bad_par);
        int   t;
        int   gaps;
        int   w;
        int   nxf;
        logic par;
        t    = 0;
        gaps = 0;
        nxf  = 8 + PBITS;
        par  = (^data) ^ bad_par;
        bus2.start = 1'b1;
        tick(); t++;
        bus2.start = 1'b0;
        exp_err = 1'b0;
        check("busy_after_start", bus2.busy, 1);
        check("ready_after_start", bus2.bit_ready, 1);
        check("err_after_start", bus2.err, exp_err);
        for (int i = 0; i < nxf; i++) begin
            bus2.bit_in    = (i < 8) ? data[7-i] : par;
            bus2.bit_valid = 1'b1;
            bus2.start     = (i == start_mid);
            check("ready_at_xfer", bus2.bit_ready, 1);
            check("cfg_hold", bus2.cfg_out, exp_cfg);
            tick(); t++;
            bus2.bit_valid = 1'b0;
            bus2.start     = 1'b0;
            if (i < nxf - 1 && gap_mask[i]) begin
                for (int g = 0; g < gap_len; g++) begin
                    check("ready_in_gap", bus2.bit_ready, 1);
                    tick(); t++;
                    gaps++;
                end
            end
        end
        check("ready_in_commit", bus2.bit_ready, 0);
        check("busy_in_commit", bus2.busy, 1);
        check("done_early", bus2.done, 0);
        check("cfg_hold_commit", bus2.cfg_out, exp_cfg);
        w = 0;
        while (bus2.done !== 1'b1 && w < 8) begin
            tick(); t++; w++;
        end
        check("done_latency", w + 1, 2);
        check("frame_cycles", t, nxf + 2 + gaps);
`ifdef C2_CFG_PARITY_EN
        if (bad_par) exp_err = 1'b1;
        else         exp_cfg = data;
`else
        exp_cfg = data;
`endif
        check("cfg_commit", bus2.cfg_out, exp_cfg);
        check("err_at_done", bus2.err, exp_err);
        check("busy_at_done", bus2.busy, 0);
    endtask

    task automatic idle_check();
        tick();
        check("done_one_cycle", bus2.done, 0);
        check("busy_idle", bus2.busy, 0);
        check("ready_idle", bus2.bit_ready, 0);
        check("cfg_idle", bus2.cfg_out, exp_cfg);
        check("err_idle", bus2.err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nib;
        int         w;
        rst = 1'b1;
        bus2.start = 1'b0; bus2.bit_in = 1'b0; bus2.bit_valid = 1'b0;
        bus1.start = 1'b0; bus1.bit_in = 1'b0; bus1.bit_valid = 1'b0;
        exp_cfg = 8'h00;
        exp_err = 1'b0;
        #12 rst = 1'b0;
        tick();
        check("rst_cfg", bus2.cfg_out, 0);
        check("rst_ready", bus2.bit_ready, 0);
        check("rst_busy", bus2.busy, 0);
        check("rst_done", bus2.done, 0);
        check("rst_err", bus2.err, 0);
        check("rst_cfg1", bus1.cfg_out, 0);

        // Basic load, then gaps after bits 2 and 5
        run_frame2(8'hA5, 16'h0000, 0, -1, 1'b0);
        idle_check();
        run_frame2(8'hA5, 16'h0012, 3, -1, 1'b0);
        idle_check();

        // Hold and reload; second start taken while done is high
        run_frame2(8'h3C, 16'h0000, 0, -1, 1'b0);
        run_frame2(8'hFF, 16'h0000, 0, -1, 1'b0);
        idle_check();

        // start mid-frame is ignored
        run_frame2(8'hA5, 16'h0000, 0, 3, 1'b0);
        idle_check();

        // Reset mid-frame aborts and clears the committed frame
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.bit_in = i[0];
            bus2.bit_valid = 1'b1;
            tick();
        end
        bus2.bit_valid = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        exp_cfg = 8'h00;
        exp_err = 1'b0;
        check("abort_cfg", bus2.cfg_out, 0);
        check("abort_ready", bus2.bit_ready, 0);
        check("abort_busy", bus2.busy, 0);
        bus2.bit_valid = 1'b1;
        tick();
        bus2.bit_valid = 1'b0;
        check("valid_in_idle_ready", bus2.bit_ready, 0);
        check("valid_in_idle_busy", bus2.busy, 0);
        check("valid_in_idle_cfg", bus2.cfg_out, 0);

`ifdef C2_CFG_PARITY_EN
        // Good parity commits; bad parity keeps old frame and sets err
        run_frame2(8'hA5, 16'h0000, 0, -1, 1'b0);
        idle_check();
        run_frame2(8'h5A, 16'h0000, 0, -1, 1'b1);
        idle_check();
        run_frame2(8'h0F, 16'h0000, 0, -1, 1'b0);
        idle_check();
`endif

        // Randomized frames, gaps and (when enabled) parity faults
        for (int k = 0; k < 20; k++) begin
            run_frame2(8'($urandom_range(255)), 16'($urandom & 32'h1FF),
                       int'($urandom_range(2)), -1, 1'($urandom_range(1)));
            if ($urandom_range(1) == 0) idle_check();
        end
        idle_check();

        // Width scaling: single cell, frame 1,1,0,1
        nib = 4'b1101;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int i = 0; i < 4 + PBITS; i++) begin
            bus1.bit_in    = (i < 4) ? nib[3-i] : ^nib;
            bus1.bit_valid = 1'b1;
            tick();
        end
        bus1.bit_valid = 1'b0;
        w = 0;
        while (bus1.done !== 1'b1 && w < 8) begin
            tick(); w++;
        end
        check("w1_done_latency", w + 1, 2);
        check("w1_cfg", bus1.cfg_out, 4'hD);
        check("w1_err", bus1.err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
